// File: rtl/accumulator_processor.sv
// Bus initiator that fetches operand pairs from a shared memory, adds them and
// writes the sum back, stopping once the memory hands out a zero operand.
module accumulator_processor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             grant,
    input  logic             signal,
    input  logic [WIDTH-1:0] read,
    output logic             req,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] write,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] add_count,
    output logic             overflow,
    output logic [7:0]       state
);

    typedef enum logic [7:0] {
        S_IDLE    = 8'h01,
        S_REQ_A   = 8'h02,
        S_FETCH_A = 8'h04,
        S_REQ_B   = 8'h08,
        S_FETCH_B = 8'h10,
        S_REQ_S   = 8'h20,
        S_SEND    = 8'h40,
        S_DONE    = 8'h80
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    state_t           r_state;
    logic [1:0]       r_op;
    logic             r_req;
    logic [WIDTH-1:0] r_write;
    logic [WIDTH-1:0] r_a;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_lone;
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, read};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_req   <= 1'b0;
            r_write <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_lone  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_REQ_A;
                end
                // Each request state spends one clock with req low so the arbiter can rotate.
                S_REQ_A, S_REQ_B, S_REQ_S: begin
                    r_op <= OP_NOP;
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (grant) begin
                        if (r_state == S_REQ_A) begin
                            r_op    <= OP_FETCH;
                            r_state <= S_FETCH_A;
                        end else if (r_state == S_REQ_B) begin
                            r_op    <= OP_FETCH;
                            r_state <= S_FETCH_B;
                        end else begin
                            r_op    <= OP_SEND;
                            r_state <= S_SEND;
                        end
                    end
                end
                S_FETCH_A: begin
                    if (signal) begin
                        r_op  <= OP_NOP;
                        r_req <= 1'b0;
                        if (read == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_a     <= read;
                            r_state <= S_REQ_B;
                        end
                    end
                end
                S_FETCH_B: begin
                    if (signal) begin
                        r_op    <= OP_NOP;
                        r_req   <= 1'b0;
                        r_state <= S_REQ_S;
                        if (read == '0) begin
                            r_write <= r_a;
                            r_lone  <= 1'b1;
                        end else begin
                            r_write <= w_sum[WIDTH-1:0];
                            r_lone  <= 1'b0;
                            if (w_sum[WIDTH]) r_ovf <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (signal) begin
                        r_op  <= OP_NOP;
                        r_req <= 1'b0;
                        if (!r_lone) r_cnt <= r_cnt + 1'b1;
                        r_state <= r_lone ? S_DONE : S_REQ_A;
                    end
                end
                S_DONE: begin
                    r_op  <= OP_NOP;
                    r_req <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_op    <= OP_NOP;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign req       = r_req;
    assign op        = r_op;
    assign write     = r_write;
    assign add_count = r_cnt;
    assign overflow  = r_ovf;
    assign state     = r_state;
    assign done      = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
